// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage: one outstanding req/gnt, data returned on rvalid.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// F-stage sequencer: owns the PC, fetches one word per PC over a variable-latency memory
// handshake and holds the result for the D stage until the hazard unit releases it.
module fetch_unit #(
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFF,
  parameter int          TIMEOUT  = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  nPC,
  input  logic         block,
  output logic [31:0]  PC,
  output logic [31:0]  Instr,
  output logic         instr_valid,
  output logic         fetch_err,
  fetch_unit_if.master imem
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             addr_err;

  // Wait counter saturates so a disabled or very long timeout never wraps back to a match.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign addr_err = (PC[1:0] != 2'b00) || (PC < IM_BASE) || (PC > (IM_LIMIT - 32'd3));

  // Request is squashed for illegal addresses and while reset is held.
  assign imem.req  = reset && (state == S_REQ) && !addr_err;
  assign imem.addr = {PC[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_REQ;
      PC          <= IM_BASE;
      Instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (addr_err) begin
            Instr       <= '0;
            fetch_err   <= 1'b1;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end else if (imem.gnt) begin
            if (imem.rvalid) begin
              Instr       <= imem.rdata;
              fetch_err   <= 1'b0;
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end else begin
              wait_cnt <= '0;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          wait_cnt <= sat_inc(wait_cnt);
          // Data arriving on the last allowed cycle wins over the timeout.
          if (imem.rvalid) begin
            Instr       <= imem.rdata;
            fetch_err   <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
            Instr       <= '0;
            fetch_err   <= 1'b1;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!block) begin
            PC          <= nPC;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            state       <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: a scripted memory responder pushes expected fetch results
// to a scoreboard and each completed fetch is popped and compared in HOLD.
module tb_fetch_unit;
  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] nPC;
  logic        block;
  logic [31:0] PC, Instr;
  logic        instr_valid, fetch_err;

  fetch_unit_if bus();

  fetch_unit #(.IM_BASE(32'h0000_3000), .IM_LIMIT(32'h0000_6FFF), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .nPC(nPC), .block(block), .PC(PC), .Instr(Instr),
    .instr_valid(instr_valid), .fetch_err(fetch_err), .imem(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; block = 1'b0; nPC = '0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    step(); step();
    reset = 1'b1;
    #1;
    exp_pc = BASE;
    sb.delete();
  endtask

  // Scripted memory: grant after g request cycles, data d cycles after the grant.
  task automatic do_fetch(input int g, input int d, input logic [31:0] data,
                          input logic give_data, input string name, output int cycles);
    exp_t e;
    cycles = 0;
    for (int i = 0; i <= g; i++) begin
      n_checks++;
      if (bus.req !== 1'b1 || bus.addr !== {exp_pc[31:2], 2'b00}) begin
        n_fail++;
        $display("FAIL %s req_phase: req=%b addr=%h, expected req=1 addr=%h", name, bus.req, bus.addr, exp_pc);
      end
      if (i < g) begin
        step();
        cycles++;
      end
    end
    bus.gnt = 1'b1;
    if (d == 0) begin bus.rvalid = 1'b1; bus.rdata = data; end
    e = '{pc: exp_pc, instr: (give_data ? data : 32'h0), err: !give_data};
    sb.push_back(e);
    step(); cycles++;
    bus.gnt = 1'b0; bus.rvalid = 1'b0;
    if (d > 0) begin
      for (int j = 1; j < d; j++) begin
        n_checks++;
        if (bus.req !== 1'b0 || instr_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s wait_phase: req=%b instr_valid=%b, expected 0 0", name, bus.req, instr_valid);
        end
        step(); cycles++;
      end
      if (give_data) begin bus.rvalid = 1'b1; bus.rdata = data; end
      step(); cycles++;
      bus.rvalid = 1'b0;
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: queue empty, expected one entry", name);
    end else begin
      e = sb.pop_front();
      if (instr_valid !== 1'b1 || PC !== e.pc || Instr !== e.instr || fetch_err !== e.err) begin
        n_fail++;
        $display("FAIL %s hold: valid=%b PC=%h Instr=%h err=%b, expected valid=1 PC=%h Instr=%h err=%b",
                 name, instr_valid, PC, Instr, fetch_err, e.pc, e.instr, e.err);
      end
    end
  endtask

  task automatic do_addr_err(input string name);
    exp_t e;
    n_checks++;
    if (bus.req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s no_req: req=%b, expected 0", name, bus.req);
    end
    sb.push_back('{pc: exp_pc, instr: 32'h0, err: 1'b1});
    step();
    n_checks++;
    e = sb.pop_front();
    if (instr_valid !== 1'b1 || PC !== e.pc || Instr !== e.instr || fetch_err !== e.err || bus.req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s err_hold: valid=%b PC=%h Instr=%h err=%b req=%b, expected valid=1 PC=%h Instr=0 err=1 req=0",
               name, instr_valid, PC, Instr, fetch_err, bus.req, e.pc);
    end
  endtask

  task automatic release_hold(input logic [31:0] npc);
    block = 1'b0; nPC = npc;
    step();
    exp_pc = npc;
    n_checks++;
    if (instr_valid !== 1'b0 || PC !== npc) begin
      n_fail++;
      $display("FAIL release: valid=%b PC=%h, expected valid=0 PC=%h", instr_valid, PC, npc);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1'b0;
    step();
    n_checks++;
    if (PC !== BASE || Instr !== 32'h0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 || bus.req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: PC=%h Instr=%h valid=%b err=%b req=%b, expected 3000 0 0 0 0",
               PC, Instr, instr_valid, fetch_err, bus.req);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.req !== 1'b1 || bus.addr !== BASE) begin
      n_fail++;
      $display("FAIL reset_first_req: req=%b addr=%h, expected 1 00003000", bus.req, bus.addr);
    end
  endtask

  task automatic test_zero_wait();
    int cyc;
    apply_reset();
    do_fetch(0, 0, 32'h2408_0001, 1'b1, "zero_wait", cyc);
    n_checks++;
    if (cyc != 1) begin n_fail++; $display("FAIL zero_wait_latency: %0d cycles, expected 1", cyc); end
    release_hold(exp_pc + 32'd4);
    n_checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h0000_3004) begin
      n_fail++;
      $display("FAIL zero_wait_next_req: req=%b addr=%h, expected 1 00003004", bus.req, bus.addr);
    end
  endtask

  task automatic test_latency();
    int cyc;
    apply_reset();
    block = 1'b1;
    do_fetch(2, 3, 32'h8C09_0004, 1'b1, "latency", cyc);
    n_checks++;
    if (cyc != 6) begin n_fail++; $display("FAIL latency_cycles: %0d cycles, expected 6", cyc); end
  endtask

  task automatic test_block();
    int cyc;
    apply_reset();
    do_fetch(0, 0, 32'h0000_0020, 1'b1, "block_fetch", cyc);
    block = 1'b1; nPC = 32'h0000_3010;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (PC !== BASE || Instr !== 32'h0000_0020 || instr_valid !== 1'b1 || bus.req !== 1'b0) begin
        n_fail++;
        $display("FAIL block_hold: PC=%h Instr=%h valid=%b req=%b, expected 3000 00000020 1 0",
                 PC, Instr, instr_valid, bus.req);
      end
    end
    release_hold(32'h0000_3010);
    n_checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h0000_3010) begin
      n_fail++;
      $display("FAIL block_release_req: req=%b addr=%h, expected 1 00003010", bus.req, bus.addr);
    end
  endtask

  task automatic test_addr_err();
    int cyc;
    apply_reset();
    do_fetch(0, 0, 32'h1111_1111, 1'b1, "pre_err", cyc);
    release_hold(32'h0000_3002);
    do_addr_err("misaligned");
    release_hold(32'h0000_7000);
    do_addr_err("above_limit");
    release_hold(32'h0000_2FFC);
    do_addr_err("below_base");
    release_hold(32'h0000_6FFC);
    do_fetch(0, 0, 32'h2222_2222, 1'b1, "top_legal_word", cyc);
  endtask

  task automatic test_timeout();
    int cyc;
    apply_reset();
    block = 1'b1;
    do_fetch(0, 4, 32'hBAD0_BAD0, 1'b0, "timeout", cyc);
    n_checks++;
    if (cyc != 5) begin n_fail++; $display("FAIL timeout_cycles: %0d cycles, expected 5", cyc); end
    release_hold(32'h0000_3004);
    do_fetch(1, 4, 32'h3C01_ABCD, 1'b1, "rvalid_last_wait", cyc);
    release_hold(32'h0000_3008);
    do_fetch(0, 2, 32'h0123_4567, 1'b1, "short_wait", cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] w;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      do_fetch(0, 0, w, 1'b1, "back_to_back", cyc);
      n_checks++;
      if (cyc != 1) begin n_fail++; $display("FAIL back_to_back_rate: %0d cycles, expected 1", cyc); end
      release_hold(exp_pc + 32'd4);
    end
  endtask

  task automatic test_reset_mid_wait();
    int cyc;
    apply_reset();
    do_fetch(0, 0, 32'hAAAA_5555, 1'b1, "pre_reset", cyc);
    release_hold(32'h0000_3008);
    bus.gnt = 1'b1;
    step();
    bus.gnt = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (PC !== BASE || Instr !== 32'h0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 || bus.req !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: PC=%h Instr=%h valid=%b err=%b req=%b, expected 3000 0 0 0 0",
               PC, Instr, instr_valid, fetch_err, bus.req);
    end
    step();
    reset = 1'b1;
    #1;
    exp_pc = BASE;
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
    step();
    bus.rvalid = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || Instr !== 32'h0) begin
      n_fail++;
      $display("FAIL stale_rvalid: valid=%b Instr=%h, expected 0 00000000", instr_valid, Instr);
    end
    do_fetch(0, 1, 32'h1234_5678, 1'b1, "fresh_after_reset", cyc);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_block();
    test_addr_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
